pc_counter: RTL and testbench

- Program-counter register for the instruction-fetch stage of the pipelined processor.
- Each clock it captures the next-PC value (`npc`) supplied by the fetch mux and presents it as `PC` to instruction memory and the PC+increment adder.
- Supports a stall hold, a priority redirect (branch/jump/exception target), a sequential next-PC output, a valid flag, and an optional misalignment flag.

---
 rtl/pc_counter.sv | 60 ++++++
 tb/tb_pc_counter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pc_counter.sv
// Program-counter register for the instruction-fetch stage.
// Captures the next PC each clock (redirect > load > stall), and exposes
// the sequential next PC, a valid flag and an optional misalignment flag.
module pc_counter #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      INC          = 4,
  parameter int unsigned      ALIGN_BITS   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] npc,
  input  logic             en,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] pc_seq,
  output logic             pc_valid,
  output logic             misaligned
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  // Modulo-2^WIDTH add; the carry out is intentionally discarded.
  function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return a + b;
  endfunction

  logic [WIDTH-1:0] pc_p0;
  logic             vld_p0;

  // Stage p0: PC register; redirect overrides stall, stall holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0  <= RESET_VECTOR;
      vld_p0 <= 1'b0;
    end else if (redirect) begin
      pc_p0  <= redirect_pc;
      vld_p0 <= 1'b1;
    end else if (en) begin
      pc_p0  <= npc;
      vld_p0 <= 1'b1;
    end
  end

  assign PC       = pc_p0;
  assign pc_valid = vld_p0;
  assign pc_seq   = wrap_add(pc_p0, INC_W);

  // Alignment check only exists when some LSBs are required to be zero.
  generate
    if (ALIGN_BITS == 0) begin : g_no_align
      assign misaligned = 1'b0;
    end else begin : g_align
      assign misaligned = |pc_p0[ALIGN_BITS-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_pc_counter.sv
// Self-checking bench for pc_counter: vector table driven through a
// scoreboard queue, plus hand-written reset and stall corner sequences.
module tb_pc_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] npc;
  logic        en;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic [31:0] pc_a, seq_a, pc_b, seq_b;
  logic        vld_a, mis_a, vld_b, mis_b;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        rd;
    logic        en;
    logic [31:0] npc;
    logic [31:0] rpc;
    logic [31:0] exp_pc;
    logic        exp_vld;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        vld;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  // Alignment-checking instance
  pc_counter #(.WIDTH(32), .RESET_VECTOR(32'h0), .INC(4), .ALIGN_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .npc(npc), .en(en), .redirect(redirect),
    .redirect_pc(redirect_pc), .PC(pc_a), .pc_seq(seq_a),
    .pc_valid(vld_a), .misaligned(mis_a)
  );

  // Default instance: alignment check disabled
  pc_counter dut0 (
    .clk(clk), .rst_n(rst_n), .npc(npc), .en(en), .redirect(redirect),
    .redirect_pc(redirect_pc), .PC(pc_b), .pc_seq(seq_b),
    .pc_valid(vld_b), .misaligned(mis_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Compare every output of both instances against one expected state.
  task automatic check_all(input string tag, input logic [31:0] epc, input logic evld);
    logic [31:0] eseq;
    eseq = epc + 32'd4;
    check({tag, ".PC"},         pc_a,  epc);
    check({tag, ".pc_valid"},   {31'b0, vld_a}, {31'b0, evld});
    check({tag, ".pc_seq"},     seq_a, eseq);
    check({tag, ".misaligned"}, {31'b0, mis_a}, {31'b0, (epc[1:0] != 2'b00)});
    check({tag, ".PC0"},        pc_b,  epc);
    check({tag, ".pc_seq0"},    seq_b, eseq);
    check({tag, ".valid0"},     {31'b0, vld_b}, {31'b0, evld});
    check({tag, ".mis0"},       {31'b0, mis_b}, 32'd0);
  endtask

  function automatic void add(input logic rd, input logic e, input logic [31:0] n,
                              input logic [31:0] r, input logic [31:0] epc, input logic ev);
    vec_t v;
    v.rd = rd; v.en = e; v.npc = n; v.rpc = r; v.exp_pc = epc; v.exp_vld = ev;
    vecs.push_back(v);
  endfunction

  // Drive one vector (called just after an edge), push its expectation,
  // then pop and compare just after the next edge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    redirect = v.rd; en = v.en; npc = v.npc; redirect_pc = v.rpc;
    e.pc = v.exp_pc; e.vld = v.exp_vld;
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check_all(tag, e.pc, e.vld);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // Release, sequential load, stall, redirect, wrap, alignment
    add(0, 1, 32'h7,        32'h0,   32'h7,        1);
    add(0, 1, 32'h0,        32'h0,   32'h0,        1);
    add(0, 1, 32'h1,        32'h0,   32'h1,        1);
    add(0, 1, 32'h2,        32'h0,   32'h2,        1);
    add(0, 1, 32'h3,        32'h0,   32'h3,        1);
    add(0, 0, 32'h9,        32'h0,   32'h3,        1);
    add(0, 0, 32'h9,        32'h0,   32'h3,        1);
    add(0, 0, 32'h9,        32'h0,   32'h3,        1);
    add(0, 1, 32'h9,        32'h0,   32'h9,        1);
    add(0, 1, 32'h4,        32'h0,   32'h4,        1);
    add(1, 0, 32'h20,       32'h100, 32'h100,      1);
    add(1, 1, 32'h20,       32'h200, 32'h200,      1);
    add(0, 1, 32'h200,      32'h0,   32'h200,      1);
    add(0, 1, 32'hFFFFFFFC, 32'h0,   32'hFFFFFFFC, 1);
    add(0, 1, 32'hFFFFFFFF, 32'h0,   32'hFFFFFFFF, 1);
    add(0, 1, 32'h6,        32'h0,   32'h6,        1);
    add(0, 1, 32'h8,        32'h0,   32'h8,        1);
    add(0, 1, 32'h40,       32'h0,   32'h40,       1);

    // Reset held with clock running and a load pending
    rst_n = 1'b0; en = 1'b1; redirect = 1'b0; npc = 32'h7; redirect_pc = 32'h0;
    #1;
    check_all("rst_async", 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_all("rst_hold", 32'h0, 1'b0);

    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // X on npc while stalled must not disturb PC
    v.rd = 0; v.en = 0; v.npc = 'x; v.rpc = 32'h0; v.exp_pc = 32'h40; v.exp_vld = 1;
    apply(v, "x_stall");

    // Asynchronous reset between edges, overriding a pending load
    en = 1'b1; npc = 32'h80;
    #2 rst_n = 1'b0;
    #1;
    check_all("rst_mid", 32'h0, 1'b0);
    @(posedge clk); #1;
    check_all("rst_mid_edge", 32'h0, 1'b0);

    // After release, valid stays low until the first load
    rst_n = 1'b1;
    v.rd = 0; v.en = 0; v.npc = 32'h44; v.rpc = 32'h0; v.exp_pc = 32'h0; v.exp_vld = 0;
    apply(v, "post_rst_stall");
    v.en = 1; v.exp_pc = 32'h44; v.exp_vld = 1;
    apply(v, "post_rst_load");

    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
